pll_reconfig_sequencer: RTL and testbench

Sequencer that drives the Avalon-MM management port of the PLL reconfiguration controller. It retunes the main PLL's fractional-M value between the NTSC and PAL master-clock plans. It supervises PLL lock and holds the core reset until the retuned PLL has been stably locked for a programmable time. It sits on the 74.25 MHz bridge clock, upstream of the reconfig controller that feeds `reconfig_to_pll`, and upstream of all core-domain reset logic.

---
 rtl/pll_reconfig_pkg.sv | 41 ++++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_reconfig_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// ---------------------------------------------------------------------------
// pll_reconfig_pkg
//   Shared definitions for the PLL reconfiguration sequencer:
//   - management-port register addresses and fixed write values
//   - sequencer state encoding
//   - default timing parameters and the counter-width helper used to size
//     the lock-stable and lock-timeout counters
// ---------------------------------------------------------------------------
package pll_reconfig_pkg;

    // Reconfig controller register map (word addresses on the mgmt port)
    localparam logic [5:0] REG_MODE  = 6'h00;
    localparam logic [5:0] REG_START = 6'h02;
    localparam logic [5:0] REG_MFRAC = 6'h07;

    // MODE = 0 selects waitrequest mode; START = 1 kicks off the reconfig
    localparam logic [31:0] MODE_WAITREQUEST = 32'd0;
    localparam logic [31:0] START_GO         = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MODE   = 3'd1,
        ST_WR_K      = 3'd2,
        ST_WR_START  = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_STABLE    = 3'd5,
        ST_RUN       = 3'd6
    } state_t;

    localparam int unsigned LOCK_STABLE_CYCLES_DEFAULT = 1024;
    localparam int unsigned LOCK_TIMEOUT_DEFAULT       = 1048576;

    // Width of a counter that runs 0 .. n-1 (never narrower than 1 bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned STABLE_CNT_W_DEFAULT  = cnt_width(LOCK_STABLE_CYCLES_DEFAULT);
    localparam int unsigned TIMEOUT_CNT_W_DEFAULT = cnt_width(LOCK_TIMEOUT_DEFAULT);

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     i_clk   - destination clock
//     i_reset - synchronous active-high reset, clears both flops
//     i_d     - asynchronous input level
//     o_q     - synchronized level, two clock edges of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reconfig_sequencer
//   Drives the Avalon-MM management port of the PLL reconfiguration
//   controller to retune the main PLL's fractional-M value between the NTSC
//   and PAL master-clock plans, then supervises lock and holds the core
//   reset until the PLL has been stably locked for LOCK_STABLE_CYCLES.
//
//   Ports:
//     i_clk_74a            - 74.25 MHz bridge clock (sole clock)
//     i_reset              - synchronous active-high reset
//     i_region_pal         - requested region, async level (1 = PAL)
//     i_pll_locked         - PLL locked, async level
//     i_mgmt_waitrequest   - reconfig controller stall
//     o_mgmt_address[5:0]  - register address (0 when no write)
//     o_mgmt_write         - write strobe
//     o_mgmt_writedata[31:0] - write data (0 when no write)
//     o_core_reset         - active-high reset for the core clock domains
//     o_pal_active         - region currently programmed into the PLL
//     o_busy               - high in every state except RUN
//     o_retry_count[3:0]   - saturating count of lock timeouts since reset
// ---------------------------------------------------------------------------
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] K_NTSC             = 32'd425936216,
    parameter logic [31:0] K_PAL              = 32'd108653137,
    parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEFAULT,
    parameter int unsigned LOCK_TIMEOUT       = LOCK_TIMEOUT_DEFAULT
) (
    input  logic        i_clk_74a,
    input  logic        i_reset,
    input  logic        i_region_pal,
    input  logic        i_pll_locked,
    input  logic        i_mgmt_waitrequest,
    output logic [5:0]  o_mgmt_address,
    output logic        o_mgmt_write,
    output logic [31:0] o_mgmt_writedata,
    output logic        o_core_reset,
    output logic        o_pal_active,
    output logic        o_busy,
    output logic [3:0]  o_retry_count
);

    localparam int unsigned STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT);

    // Terminal counts: the counters start at 0, so N cycles end at N-1
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = region request, bit 1 = PLL lock
    // ------------------------------------------------------------------
    logic [1:0] w_async;
    logic [1:0] w_sync;
    logic       w_region_sync;
    logic       w_lock_sync;

    assign w_async = {i_pll_locked, i_region_pal};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            sync_2ff u_sync (
                .i_clk   (i_clk_74a),
                .i_reset (i_reset),
                .i_d     (w_async[gi]),
                .o_q     (w_sync[gi])
            );
        end
    endgenerate

    assign w_region_sync = w_sync[0];
    assign w_lock_sync   = w_sync[1];

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_target;       // region latched for the current pass
    logic             r_pal_active;
    logic             r_core_reset;
    logic             r_busy;
    logic             r_mgmt_write;
    logic [5:0]       r_mgmt_address;
    logic [31:0]      r_mgmt_writedata;
    logic [3:0]       r_retry_count;
    logic [STB_W-1:0] r_stable_cnt;
    logic [TMO_W-1:0] r_timeout_cnt;

    // Every transition into a new state also loads the bus registers that
    // the new state presents, so the mgmt outputs come straight from flops
    // and appear in the first cycle of each WR_* state.
    always_ff @(posedge i_clk_74a) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_target         <= 1'b0;
            r_pal_active     <= 1'b0;
            r_core_reset     <= 1'b1;
            r_busy           <= 1'b1;
            r_mgmt_write     <= 1'b0;
            r_mgmt_address   <= '0;
            r_mgmt_writedata <= '0;
            r_retry_count    <= '0;
            r_stable_cnt     <= '0;
            r_timeout_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state          <= ST_WR_MODE;
                    r_target         <= w_region_sync;
                    r_mgmt_write     <= 1'b1;
                    r_mgmt_address   <= REG_MODE;
                    r_mgmt_writedata <= MODE_WAITREQUEST;
                end

                ST_WR_MODE: begin
                    if (!i_mgmt_waitrequest) begin
                        r_state          <= ST_WR_K;
                        r_mgmt_address   <= REG_MFRAC;
                        r_mgmt_writedata <= r_target ? K_PAL : K_NTSC;
                    end
                end

                ST_WR_K: begin
                    if (!i_mgmt_waitrequest) begin
                        r_state          <= ST_WR_START;
                        r_pal_active     <= r_target;
                        r_mgmt_address   <= REG_START;
                        r_mgmt_writedata <= START_GO;
                    end
                end

                ST_WR_START: begin
                    if (!i_mgmt_waitrequest) begin
                        r_state          <= ST_WAIT_LOCK;
                        r_mgmt_write     <= 1'b0;
                        r_mgmt_address   <= '0;
                        r_mgmt_writedata <= '0;
                        r_timeout_cnt    <= '0;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (w_lock_sync) begin
                        r_state      <= ST_STABLE;
                        r_stable_cnt <= '0;
                    end else if (r_timeout_cnt == TMO_LAST) begin
                        // No lock within the budget: rerun the whole pass
                        // with the same latched target.
                        r_state          <= ST_WR_MODE;
                        r_timeout_cnt    <= '0;
                        r_mgmt_write     <= 1'b1;
                        r_mgmt_address   <= REG_MODE;
                        r_mgmt_writedata <= MODE_WAITREQUEST;
                        if (r_retry_count != 4'hF) begin
                            r_retry_count <= r_retry_count + 4'd1;
                        end
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + TMO_W'(1);
                    end
                end

                ST_STABLE: begin
                    if (!w_lock_sync) begin
                        r_state       <= ST_WAIT_LOCK;
                        r_stable_cnt  <= '0;
                        r_timeout_cnt <= '0;
                    end else if (r_stable_cnt == STB_LAST) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + STB_W'(1);
                    end
                end

                ST_RUN: begin
                    // A region change takes priority over lock loss: the
                    // reprogramming pass ends in WAIT_LOCK anyway.
                    if (w_region_sync != r_pal_active) begin
                        r_state          <= ST_WR_MODE;
                        r_target         <= w_region_sync;
                        r_core_reset     <= 1'b1;
                        r_busy           <= 1'b1;
                        r_mgmt_write     <= 1'b1;
                        r_mgmt_address   <= REG_MODE;
                        r_mgmt_writedata <= MODE_WAITREQUEST;
                    end else if (!w_lock_sync) begin
                        r_state       <= ST_WAIT_LOCK;
                        r_core_reset  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_timeout_cnt <= '0;
                    end
                end

                default: begin
                    r_state          <= ST_IDLE;
                    r_core_reset     <= 1'b1;
                    r_busy           <= 1'b1;
                    r_mgmt_write     <= 1'b0;
                    r_mgmt_address   <= '0;
                    r_mgmt_writedata <= '0;
                end
            endcase
        end
    end

    assign o_mgmt_address   = r_mgmt_address;
    assign o_mgmt_write     = r_mgmt_write;
    assign o_mgmt_writedata = r_mgmt_writedata;
    assign o_core_reset     = r_core_reset;
    assign o_pal_active     = r_pal_active;
    assign o_busy           = r_busy;
    assign o_retry_count    = r_retry_count;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_sequencer
//   Directed bench for pll_reconfig_sequencer. Expected management writes are
//   queued when a programming pass is provoked and popped by a bus monitor
//   as the DUT completes each write; timing and status outputs are checked
//   inline by the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_sequencer;
    import pll_reconfig_pkg::*;

    localparam logic [31:0] K_NTSC_TB = 32'd425936216;
    localparam logic [31:0] K_PAL_TB  = 32'd108653137;

    logic        clk;
    logic        rst;
    logic        region_pal;
    logic        pll_locked;
    logic        waitreq;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        core_reset;
    logic        pal_active;
    logic        busy;
    logic [3:0]  retry_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    pll_reconfig_sequencer #(
        .K_NTSC             (K_NTSC_TB),
        .K_PAL              (K_PAL_TB),
        .LOCK_STABLE_CYCLES (1024),
        .LOCK_TIMEOUT       (64)
    ) dut (
        .i_clk_74a          (clk),
        .i_reset            (rst),
        .i_region_pal       (region_pal),
        .i_pll_locked       (pll_locked),
        .i_mgmt_waitrequest (waitreq),
        .o_mgmt_address     (mgmt_address),
        .o_mgmt_write       (mgmt_write),
        .o_mgmt_writedata   (mgmt_writedata),
        .o_core_reset       (core_reset),
        .o_pal_active       (pal_active),
        .o_busy             (busy),
        .o_retry_count      (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic push_pass(input logic [31:0] k);
        exp_q.push_back('{addr: REG_MODE,  data: MODE_WAITREQUEST});
        exp_q.push_back('{addr: REG_MFRAC, data: k});
        exp_q.push_back('{addr: REG_START, data: START_GO});
    endtask

    // Bus monitor: each accepted write must match the head of the queue;
    // an idle bus must show zero address and data.
    always @(negedge clk) begin
        if (mgmt_write && !waitreq) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mgmt_address), 64'(e.addr));
                chk("wr_data", 64'(mgmt_writedata), 64'(e.data));
                $display("write accepted cyc=%0d addr=0x%02h data=%0d", cyc, mgmt_address, mgmt_writedata);
            end
        end else if (!mgmt_write) begin
            chk("idle_bus", {26'd0, mgmt_address, mgmt_writedata}, 64'd0);
        end
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int prev_cyc;
        logic found;

        rst        = 1'b1;
        region_pal = 1'b0;
        pll_locked = 1'b0;
        waitreq    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_data", 64'(mgmt_writedata), 64'd0);
        chk("rst_pal_active", 64'(pal_active), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_retry", 64'(retry_count), 64'd0);

        // ---------------- NTSC bring-up ----------------
        push_pass(K_NTSC_TB);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ntsc_c1_write", 64'(mgmt_write), 64'd1);
        chk("ntsc_c1_addr", 64'(mgmt_address), 64'(REG_MODE));
        @(posedge clk); #1;
        chk("ntsc_c2_addr", 64'(mgmt_address), 64'(REG_MFRAC));
        chk("ntsc_c2_data", 64'(mgmt_writedata), 64'(K_NTSC_TB));
        @(posedge clk); #1;
        chk("ntsc_c3_addr", 64'(mgmt_address), 64'(REG_START));
        chk("ntsc_c3_data", 64'(mgmt_writedata), 64'd1);
        @(posedge clk); #1;
        chk("ntsc_c4_write", 64'(mgmt_write), 64'd0);
        chk("ntsc_wait_core_reset", 64'(core_reset), 64'd1);

        pll_locked = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk); n++; #1;
            if (!core_reset) break;
        end
        $display("lock to core release: %0d cycles", n);
        chk("ntsc_release_cycles", 64'(n), 64'd1027);
        chk("ntsc_run_busy", 64'(busy), 64'd0);
        chk("ntsc_pal_active", 64'(pal_active), 64'd0);
        chk("ntsc_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- region change to PAL, stalled WR_K ----------------
        push_pass(K_PAL_TB);
        region_pal = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge clk); n++; #1;
            if (core_reset) break;
        end
        $display("region toggle to core_reset: %0d cycles", n);
        chk("pal_reset_within_3", 64'(n >= 1 && n <= 3), 64'd1);
        chk("pal_mode_addr", 64'(mgmt_address), 64'(REG_MODE));
        chk("pal_busy", 64'(busy), 64'd1);

        @(posedge clk); #1;
        waitreq = 1'b1;
        chk("pal_k_addr_0", 64'(mgmt_address), 64'(REG_MFRAC));
        chk("pal_k_data_0", 64'(mgmt_writedata), 64'(K_PAL_TB));
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk("pal_k_hold_write", 64'(mgmt_write), 64'd1);
            chk("pal_k_hold_addr", 64'(mgmt_address), 64'(REG_MFRAC));
            chk("pal_k_hold_data", 64'(mgmt_writedata), 64'(K_PAL_TB));
            chk("pal_k_hold_pal_active", 64'(pal_active), 64'd0);
            if (i == 5) waitreq = 1'b0;
        end
        @(posedge clk); #1;
        chk("pal_start_addr", 64'(mgmt_address), 64'(REG_START));
        chk("pal_active_after_k", 64'(pal_active), 64'd1);
        @(posedge clk); #1;
        chk("pal_write_done", 64'(mgmt_write), 64'd0);
        n = 0;
        while (n < 2000) begin
            @(posedge clk); n++; #1;
            if (!core_reset) break;
        end
        chk("pal_release_cycles", 64'(n), 64'd1025);
        chk("pal_run_busy", 64'(busy), 64'd0);
        chk("pal_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- lock loss in RUN, then glitch in STABLE ----------------
        pll_locked = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge clk); n++; #1;
            if (core_reset) break;
        end
        chk("lockloss_reset_cycles", 64'(n), 64'd3);
        chk("lockloss_no_write", 64'(mgmt_write), 64'd0);
        chk("lockloss_pal_kept", 64'(pal_active), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        pll_locked = 1'b1;
        repeat (503) @(posedge clk);
        #1;
        chk("glitch_still_held", 64'(core_reset), 64'd1);
        pll_locked = 1'b0;
        @(posedge clk); #1;
        pll_locked = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk); n++; #1;
            if (!core_reset) break;
        end
        $display("relock after glitch to core release: %0d cycles", n);
        chk("glitch_release_cycles", 64'(n), 64'd1027);
        chk("glitch_sb_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- lock never returns: retry loop ----------------
        pll_locked = 1'b0;
        prev_cyc = 0;
        for (int p = 1; p <= 17; p++) begin
            push_pass(K_PAL_TB);
            found = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(posedge clk); #1;
                if (mgmt_write && mgmt_address == REG_MODE) begin
                    found = 1'b1;
                    break;
                end
            end
            $display("retry pass %0d at cyc=%0d retry_count=%0d", p, cyc, retry_count);
            chk("retry_pass_seen", 64'(found), 64'd1);
            if (p > 1) chk("retry_period", 64'(cyc - prev_cyc), 64'd67);
            chk("retry_count", 64'(retry_count), (p > 15) ? 64'd15 : 64'(p));
            chk("retry_core_reset", 64'(core_reset), 64'd1);
            prev_cyc = cyc;
        end

        // ---------------- reset asserted mid-transaction ----------------
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midrst_write", 64'(mgmt_write), 64'd0);
        chk("midrst_retry", 64'(retry_count), 64'd0);
        chk("midrst_pal_active", 64'(pal_active), 64'd0);
        chk("midrst_core_reset", 64'(core_reset), 64'd1);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
